// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer.
// Holds state encodings, opcode constants, ALUOp/ALUControl codes and mux
// select constants, plus small opcode helpers used by the top and the bench-facing debug port.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_JAL      = 4'd9,
        ST_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        logic [1:0] imm;
        imm = IMM_I;
        case (opcode)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

    function automatic logic is_supported(input logic [6:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
               (opcode == OP_I)  || (opcode == OP_JAL) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: maps ALUOp plus func3/func7/opcode to the 3-bit ALUControl code.
// Purely combinational, zero latency; no flow control.
// Ports: alu_op, opcode, func3, func7 in; alu_control out.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    output logic [2:0]  alu_control
);

    // Only func7[5] distinguishes add/sub; the other bits are don't-care here.
    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNC: begin
                case (func3)
                    // I-type addi has no sub form, so func7[5] only matters for R-type.
                    3'b000:  alu_control = ((opcode == OP_R) && func7[5]) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control = ALUC_SLT;
                    3'b110:  alu_control = ALUC_OR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer (lw, sw, R/I ALU, beq, jal) as a Moore FSM.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles with zero wait states; outputs decoded from state.
// Backpressure: FETCH and MEMREAD/MEMWRITE hold until mem_ready; mem_req/MemWrite stay up meanwhile.
// Ports: clk, rst (sync, active-low), instruction fields, Zero, mem_ready in; datapath controls,
// illegal_instr and fsm_state out. Define MC_PERF_CNT_EN to add cycle_cnt/instret_cnt counters.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        Opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic              Zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [2:0]        ALUControl,
    output logic [1:0]        ImmSrc,
    output logic              RegWrite,
    output logic              illegal_instr,
    output logic [3:0]        fsm_state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
`endif
);

    state_t     state;
    alu_op_t    alu_op;
    logic       pc_update;
    logic       branch;
    logic [2:0] alu_control_raw;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:    if (mem_ready) state <= ST_DECODE;
                ST_DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW: state <= ST_MEMADR;
                        OP_R:         state <= ST_EXECR;
                        OP_I:         state <= ST_EXECI;
                        OP_JAL:       state <= ST_JAL;
                        OP_BEQ:       state <= ST_BEQ;
                        default:      state <= ST_FETCH;
                    endcase
                end
                ST_MEMADR:   state <= (Opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
                ST_MEMREAD:  if (mem_ready) state <= ST_MEMWB;
                ST_MEMWB:    state <= ST_FETCH;
                ST_MEMWRITE: if (mem_ready) state <= ST_FETCH;
                ST_EXECR:    state <= ST_ALUWB;
                ST_EXECI:    state <= ST_ALUWB;
                ST_ALUWB:    state <= ST_FETCH;
                ST_JAL:      state <= ST_ALUWB;
                ST_BEQ:      state <= ST_FETCH;
                default:     state <= ST_FETCH;
            endcase
        end
    end

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .opcode      (Opcode),
        .func3       (func3),
        .func7       (func7),
        .alu_control (alu_control_raw)
    );

    // Whole decode is gated by rst so a reset mid-instruction suppresses
    // RegWrite/MemWrite in the same cycle rst falls.
    always_comb begin
        mem_req       = 1'b0;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ImmSrc        = IMM_I;
        RegWrite      = 1'b0;
        illegal_instr = 1'b0;
        fsm_state     = 4'd0;
        alu_op        = ALUOP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        if (rst) begin
            fsm_state = state;
            ImmSrc    = imm_src_of(Opcode);
            case (state)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    IRWrite   = mem_ready;
                    pc_update = mem_ready;
                end
                ST_DECODE: begin
                    ALUSrcA       = SRCA_OLDPC;
                    ALUSrcB       = SRCB_IMM;
                    illegal_instr = !is_supported(Opcode);
                end
                ST_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                ST_MEMWB: begin
                    ResultSrc = RES_READDATA;
                    RegWrite  = 1'b1;
                end
                ST_MEMWRITE: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                ST_EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    alu_op  = ALUOP_FUNC;
                end
                ST_EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    alu_op  = ALUOP_FUNC;
                end
                ST_ALUWB: begin
                    RegWrite = 1'b1;
                end
                ST_JAL: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    pc_update = 1'b1;
                end
                ST_BEQ: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    alu_op  = ALUOP_SUB;
                    branch  = 1'b1;
                end
                default: ;
            endcase
            PCWrite = pc_update | (branch & Zero);
        end
    end

    assign ALUControl = rst ? alu_control_raw : 3'b000;

`ifdef MC_PERF_CNT_EN
    logic retire;

    assign retire = (state == ST_MEMWB) || (state == ST_ALUWB) || (state == ST_BEQ) ||
                    ((state == ST_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    // Clock starts high: each cycle's inputs are driven 1 after posedge and
    // sampled at the following negedge, before the next posedge.
    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] Opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       Zero, mem_ready;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] fsm_state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .func3(func3), .func7(func7),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .illegal_instr(illegal_instr), .fsm_state(fsm_state)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // Instruction classes and step numbers as the specification numbers them.
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, XR = 6, XI = 7,
                   AWB = 8, J = 9, B = 10;

    typedef struct packed {
        logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite;
        logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
        logic [2:0] ALUControl;
        logic [1:0] ImmSrc;
        logic       RegWrite, illegal;
        logic [3:0] state;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  rst;
        logic  ret;
    } rec_t;

    rec_t q[$];
    int n_tests = 0, n_fail = 0;
    int obs_cycles, obs_irw, obs_rw, obs_mw, obs_ill, obs_pcw_beq, obs_rw_rd, obs_adr_mw;
    int last_aluc_beq, last_imm_mw;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    logic [31:0] m_cyc = 0, m_ret = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ALUControl, ImmSrc, RegWrite, illegal_instr, fsm_state};
        return o;
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] op);
        if (op == SW) return 2'd1;
        if (op == BQ) return 2'd2;
        if (op == JL) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [2:0] ref_func(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
        case (f3)
            3'd0:    return (op == RT && f7[5]) ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return op == LW || op == SW || op == RT || op == IT || op == JL || op == BQ;
    endfunction

    // Drive one cycle of instruction step st and queue what the outputs must be.
    task automatic drive_cyc(input int st, input logic rdy, input logic z, input logic ret);
        outs_t e;
        rst = 1'b1; Opcode = cur_op; func3 = cur_f3; func7 = cur_f7;
        mem_ready = rdy; Zero = z;
        e = '0;
        e.state  = 4'(st);
        e.ImmSrc = ref_imm(cur_op);
        case (st)
            F:   begin e.mem_req = 1; e.ALUSrcB = 2; e.ResultSrc = 2;
                       e.IRWrite = rdy; e.PCWrite = rdy; end
            D:   begin e.ALUSrcA = 1; e.ALUSrcB = 1; e.illegal = !legal(cur_op); end
            MA:  begin e.ALUSrcA = 2; e.ALUSrcB = 1; end
            MR:  begin e.mem_req = 1; e.AdrSrc = 1; end
            MWB: begin e.ResultSrc = 1; e.RegWrite = 1; end
            MW:  begin e.mem_req = 1; e.AdrSrc = 1; e.MemWrite = 1; end
            XR:  begin e.ALUSrcA = 2; e.ALUControl = ref_func(cur_op, cur_f3, cur_f7); end
            XI:  begin e.ALUSrcA = 2; e.ALUSrcB = 1;
                       e.ALUControl = ref_func(cur_op, cur_f3, cur_f7); end
            AWB: e.RegWrite = 1;
            J:   begin e.ALUSrcA = 1; e.ALUSrcB = 2; e.PCWrite = 1; end
            B:   begin e.ALUSrcA = 2; e.ALUControl = 3'd1; e.PCWrite = z; end
            default: ;
        endcase
        q.push_back('{o: e, rst: 1'b1, ret: ret});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int st, input logic rdy, input logic z, input logic ret);
        drive_cyc(st, rdy, z, ret);
        step();
    endtask

    task automatic rst_cyc();
        rst = 1'b0; Opcode = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
        mem_ready = rb(); Zero = rb();
        q.push_back('{o: '0, rst: 1'b0, ret: 1'b0});
        #3 check("reset_outputs_zero", 32'(dut_outs()), 32'd0);
        step();
    endtask

    task automatic zero_obs();
        obs_cycles = 0; obs_irw = 0; obs_rw = 0; obs_mw = 0; obs_ill = 0;
        obs_pcw_beq = 0; obs_rw_rd = 0; obs_adr_mw = 0; last_aluc_beq = -1; last_imm_mw = -1;
    endtask

    // One whole instruction: fw FETCH wait states, mw memory wait states.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fw, input int mw, input logic z);
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
        for (int i = 0; i < fw; i++) cyc(F, 1'b0, rb(), 1'b0);
        cyc(F, 1'b1, rb(), 1'b0);
        cyc(D, rb(), rb(), 1'b0);
        if (op == LW) begin
            cyc(MA, rb(), rb(), 1'b0);
            for (int i = 0; i < mw; i++) cyc(MR, 1'b0, rb(), 1'b0);
            cyc(MR, 1'b1, rb(), 1'b0);
            cyc(MWB, rb(), rb(), 1'b1);
        end else if (op == SW) begin
            cyc(MA, rb(), rb(), 1'b0);
            for (int i = 0; i < mw; i++) cyc(MW, 1'b0, rb(), 1'b0);
            cyc(MW, 1'b1, rb(), 1'b1);
        end else if (op == RT || op == IT || op == JL) begin
            cyc(op == RT ? XR : (op == IT ? XI : J), rb(), rb(), 1'b0);
            cyc(AWB, rb(), rb(), 1'b1);
        end else if (op == BQ) begin
            cyc(B, rb(), z, 1'b1);
        end
    endtask

    // Compare process: every queued cycle is checked against the DUT at negedge.
    initial begin
        rec_t r;
        outs_t g;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                g = dut_outs();
                check($sformatf("outputs step=%0d", r.o.state), 32'(g), 32'(r.o));
                obs_cycles++;
                obs_irw += int'(IRWrite);
                obs_rw  += int'(RegWrite);
                obs_mw  += int'(MemWrite);
                obs_ill += int'(illegal_instr);
                if (RegWrite && ResultSrc == 2'b01) obs_rw_rd++;
                if (MemWrite && AdrSrc) obs_adr_mw++;
                if (MemWrite) last_imm_mw = int'(ImmSrc);
                if (fsm_state == 4'd10) begin
                    obs_pcw_beq  += int'(PCWrite);
                    last_aluc_beq = int'(ALUControl);
                end
`ifdef MC_PERF_CNT_EN
                if (r.rst) begin
                    check("cycle_cnt", cycle_cnt, m_cyc);
                    check("instret_cnt", instret_cnt, m_ret);
                end
                if (!r.rst) begin m_cyc = 0; m_ret = 0; end
                else begin m_cyc = m_cyc + 1; m_ret = m_ret + 32'(r.ret); end
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles, then an add written out step by step.
        rst_cyc();
        rst_cyc();
        zero_obs();
        cur_op = RT; cur_f3 = 3'b000; cur_f7 = 7'b0000000;
        drive_cyc(F, 1'b1, 1'b0, 1'b0);
        #3;
        check("post_reset_state", 32'(fsm_state), 32'd0);
        check("post_reset_mem_req", 32'(mem_req), 32'd1);
        step();
        cyc(D, 1'b1, 1'b0, 1'b0);
        drive_cyc(XR, 1'b1, 1'b0, 1'b0);
        #3 check("add_execr_aluc", 32'(ALUControl), 32'd0);
        check("add_execr_state", 32'(fsm_state), 32'd6);
        step();
        cyc(AWB, 1'b1, 1'b0, 1'b1);
        check("add_cycles", 32'(obs_cycles), 32'd4);
        check("add_regwrite_count", 32'(obs_rw), 32'd1);

        // lw, 2 wait states in FETCH and in MEMREAD.
        zero_obs();
        run_instr(LW, 3'b010, 7'd0, 2, 2, 1'b0);
        check("lw_cycles", 32'(obs_cycles), 32'd9);
        check("lw_irwrite_pulses", 32'(obs_irw), 32'd1);
        check("lw_regwrite_readdata", 32'(obs_rw_rd), 32'd1);

        // beq taken then not taken.
        zero_obs();
        run_instr(BQ, 3'b000, 7'd0, 0, 0, 1'b1);
        check("beq_taken_pcwrite", 32'(obs_pcw_beq), 32'd1);
        check("beq_aluc", 32'(last_aluc_beq), 32'd1);
        check("beq_cycles", 32'(obs_cycles), 32'd3);
        zero_obs();
        cur_op = BQ;
        drive_cyc(F, 1'b1, 1'b0, 1'b0);
        #3 check("beq_immsrc", 32'(ImmSrc), 32'd2);
        step();
        cyc(D, 1'b1, 1'b1, 1'b0);
        cyc(B, 1'b1, 1'b0, 1'b1);
        check("beq_not_taken_pcwrite", 32'(obs_pcw_beq), 32'd0);

        // sw with 2 wait states in MEMWRITE.
        zero_obs();
        run_instr(SW, 3'b010, 7'd0, 0, 2, 1'b0);
        check("sw_cycles", 32'(obs_cycles), 32'd6);
        check("sw_memwrite_cycles", 32'(obs_mw), 32'd3);
        check("sw_adrsrc_with_mw", 32'(obs_adr_mw), 32'd3);
        check("sw_immsrc", 32'(last_imm_mw), 32'd1);
        check("sw_no_regwrite", 32'(obs_rw), 32'd0);

        // Unsupported opcode.
        zero_obs();
        run_instr(7'b1110011, 3'd0, 7'd0, 0, 0, 1'b0);
        check("illegal_cycles", 32'(obs_cycles), 32'd2);
        check("illegal_pulses", 32'(obs_ill), 32'd1);
        check("illegal_side_effects", 32'(obs_rw + obs_mw), 32'd0);

        // Reset while a store is waiting on memory.
        zero_obs();
        cur_op = SW; cur_f3 = 3'b010; cur_f7 = 7'd0;
        cyc(F, 1'b1, 1'b0, 1'b0);
        cyc(D, 1'b1, 1'b0, 1'b0);
        cyc(MA, 1'b1, 1'b0, 1'b0);
        cyc(MW, 1'b0, 1'b0, 1'b0);
        rst_cyc();
        rst_cyc();
        check("abort_memwrite_cycles", 32'(obs_mw), 32'd1);

        // Three adds straight after reset.
        for (int i = 0; i < 3; i++) run_instr(RT, 3'b000, 7'd0, 0, 0, 1'b0);
`ifdef MC_PERF_CNT_EN
        cur_op = RT;
        drive_cyc(F, 1'b0, 1'b0, 1'b0);
        #3 check("perf_instret_3_adds", instret_cnt, 32'd3);
        check("perf_cycles_3_adds", cycle_cnt, 32'd12);
        step();
`endif

        // Random instruction stream with occasional resets.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 6))
                0:       op = LW;
                1:       op = SW;
                2:       op = RT;
                3:       op = IT;
                4:       op = JL;
                5:       op = BQ;
                default: op = 7'($urandom);
            endcase
            if ($urandom_range(0, 19) == 0) rst_cyc();
            run_instr(op, 3'($urandom), 7'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), rb());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I datapath subset (lw, sw, R-type ALU, I-type ALU, beq, jal). It replaces single-cycle decode with a registered Moore FSM and drives the shared-memory, shared-ALU datapath step by step: FETCH, DECODE, EXECUTE, MEM, WB. A mem_req/mem_ready handshake on the unified instruction/data memory allows wait states.

Parameters:
CNT_W, 32, width of the performance counters (used only with MC_PERF_CNT_EN).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-low reset
Opcode  in  7  instr[6:0] from instruction register
func3  in  3  instr[14:12]
func7  in  7  instr[31:25]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
PCWrite  out  1  PC register enable
AdrSrc  out  1  0=PC, 1=ALUOut as memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register / OldPC enable
ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
RegWrite  out  1  register file write enable
illegal_instr  out  1  one-cycle pulse on unsupported opcode
fsm_state  out  4  current state, for debug

Behaviour:
- Reset: rst sampled low at a clk edge sets state to FETCH. While rst==0, all outputs are 0 (combinational gating).
- Registered state; outputs are decoded from state combinationally. Exceptions: PCWrite also depends on Zero; IRWrite and PCWrite in FETCH also depend on mem_ready.
- FETCH (0): mem_req=1, AdrSrc=0, SrcA=00, SrcB=10, ALUOp add, ResultSrc=10.
  - IRWrite and PCUpdate asserted only when mem_ready=1.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (1): SrcA=01, SrcB=01, ALUOp add (branch target computed into ALUOut). Next state by Opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other opcode -> FETCH with illegal_instr=1 for this cycle; no register or memory side effects.
- MEMADR (2): SrcA=10, SrcB=01, add. Goes to MEMREAD if lw, MEMWRITE if sw.
- MEMREAD (3): mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready, then goes to MEMWB.
- MEMWB (4): ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE (5): mem_req=1, AdrSrc=1, MemWrite=1 (held through wait states). Goes to FETCH on mem_ready.
- EXECR (6): SrcA=10, SrcB=00, ALUOp func. Goes to ALUWB.
- EXECI (7): SrcA=10, SrcB=01, ALUOp func. Goes to ALUWB.
- ALUWB (8): ResultSrc=00, RegWrite=1. Goes to FETCH.
- JAL (9): SrcA=01, SrcB=10 (OldPC+4), ResultSrc=00 (target), PCUpdate=1. Goes to ALUWB.
- BEQ (10): SrcA=10, SrcB=00, ALUOp sub, ResultSrc=00, Branch=1. Goes to FETCH.
- PCWrite = PCUpdate | (Branch & Zero).
- Encodings 11-15 are unreachable; if entered, next state is FETCH.
- ImmSrc is decoded from Opcode in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, otherwise 00.
- ALUOp to ALUControl:
  - add -> 000
  - sub -> 001
  - func, by func3: 000 -> sub only if Opcode==0110011 and func7[5]=1, else add; 010 -> slt; 110 -> or; 111 -> and; other func3 -> add.
- Instruction cycle counts with zero wait states: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Mid-operation reset aborts the instruction immediately; no partial RegWrite/MemWrite is issued after rst falls.

Optional Feature:
MC_PERF_CNT_EN
- Defined: adds output ports cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0], both cleared on reset.
  - cycle_cnt increments every cycle rst==1.
  - instret_cnt increments on each transition into FETCH from MEMWB, MEMWRITE(ready), ALUWB or BEQ.
  - Both wrap modulo 2^CNT_W.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - ALUOp codes (add/sub/func)
  - ALUControl codes
  - ResultSrc/ALUSrcA/ALUSrcB/ImmSrc field constants
- One sub-module: mc_alu_decoder (combinational ALUOp/func3/func7/Opcode -> ALUControl).

Test Plan:
- Reset: rst=0 for 2 cycles, then rst=1 -> fsm_state=0, all outputs 0 during reset, mem_req=1 the first cycle after.
- add (0110011, f3=000, f7=0000000), mem_ready=1 -> states 0,1,6,8,0; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
- lw with 2 wait states in FETCH and MEMREAD (mem_ready low 2 cycles each) -> 9 cycles total; IRWrite pulses exactly once; RegWrite with ResultSrc=01 in MEMWB.
- beq with Zero=1, then repeated with Zero=0 -> PCWrite=1 / 0 in BEQ state; ALUControl=001; ImmSrc=10.
- sw -> MemWrite=1 only in MEMWRITE, held through wait states, AdrSrc=1, ImmSrc=01; RegWrite never asserted.
- Opcode 1110011 -> illegal_instr=1 for one cycle in DECODE, next state FETCH, no RegWrite/MemWrite. With MC_PERF_CNT_EN, after 3 add instructions instret_cnt=3.
